// File: rtl/exec_sequencer.sv
// Per-instruction sequencer: FETCH -> LO -> HI -> optional MEM, with halt parking and retire counting.
// Optional dmem watchdog enabled by defining EXEC_SEQ_WDOG_EN.
module exec_sequencer #(
    parameter int TIMEOUT_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_o,
    input  logic             imem_ack_i,
    output logic             ir_load_o,
    output logic             first_cycle_o,
    input  logic             mem_i,
    input  logic             store_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    input  logic             dmem_ack_i,
    input  logic             jmp_i,
    input  logic             branch_i,
    input  logic             taken_i,
    input  logic             halt_i,
    output logic             pc_en_o,
    output logic             pc_redirect_o,
    output logic             halted_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] instret_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LO    = 3'd2,
        S_HI    = 3'd3,
        S_MEM   = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t           state_q;
    logic             imem_req_q;
    logic             first_cycle_q;
    logic             dmem_req_q;
    logic             dmem_we_q;
    logic             halted_q;
    logic [CNT_W-1:0] instret_q;

    logic hi_retire;
    logic mem_done;
    logic wdog_expire;

    if (TIMEOUT_W < 1) begin : g_bad_timeout_w
        $error("exec_sequencer: TIMEOUT_W must be at least 1");
    end

    assign hi_retire = (state_q == S_HI) & ~mem_i;
    assign mem_done  = (state_q == S_MEM) & (dmem_ack_i | wdog_expire);

`ifdef EXEC_SEQ_WDOG_EN
    logic [TIMEOUT_W-1:0] wdog_q;
    logic                 mem_err_q;

    assign wdog_expire = (state_q == S_MEM) & ~dmem_ack_i & (&wdog_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            if ((state_q == S_HI) && mem_i) begin
                wdog_q <= '0;
            end else if ((state_q == S_MEM) && !dmem_ack_i) begin
                wdog_q <= wdog_q + 1'b1;
            end
            if (wdog_expire) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    assign mem_err_o = mem_err_q;
`else
    assign wdog_expire = 1'b0;
    assign mem_err_o   = 1'b0;
`endif

    // Moore outputs come straight from flops loaded with the next state's value,
    // so first_cycle_o cannot glitch when it gates the downstream decode latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            imem_req_q    <= 1'b0;
            first_cycle_q <= 1'b0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_FETCH;
                    imem_req_q <= ~halt_i;
                end
                S_FETCH: begin
                    // An accepted fetch is already in flight, so it wins over halt.
                    if (imem_req_q && imem_ack_i) begin
                        state_q       <= S_LO;
                        imem_req_q    <= 1'b0;
                        first_cycle_q <= 1'b1;
                    end else if (halt_i) begin
                        state_q    <= S_HALT;
                        imem_req_q <= 1'b0;
                        halted_q   <= 1'b1;
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end
                S_LO: begin
                    state_q       <= S_HI;
                    first_cycle_q <= 1'b0;
                end
                S_HI: begin
                    if (mem_i) begin
                        state_q    <= S_MEM;
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= store_i;
                    end else begin
                        state_q    <= S_FETCH;
                        imem_req_q <= ~halt_i;
                    end
                end
                S_MEM: begin
                    if (mem_done) begin
                        state_q    <= S_FETCH;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        imem_req_q <= ~halt_i;
                    end
                end
                S_HALT: begin
                    if (!halt_i) begin
                        state_q    <= S_FETCH;
                        halted_q   <= 1'b0;
                        imem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    imem_req_q    <= 1'b0;
                    first_cycle_q <= 1'b0;
                    dmem_req_q    <= 1'b0;
                    dmem_we_q     <= 1'b0;
                    halted_q      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (pc_en_o) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign imem_req_o    = imem_req_q;
    assign ir_load_o     = imem_req_q & imem_ack_i;
    assign first_cycle_o = first_cycle_q;
    assign dmem_req_o    = dmem_req_q;
    assign dmem_we_o     = dmem_we_q;
    assign halted_o      = halted_q;
    assign pc_en_o       = hi_retire | mem_done;
    assign pc_redirect_o = hi_retire & (jmp_i | (branch_i & taken_i));
    assign instret_o     = instret_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: per-instruction latency/strobe model driven by randomized instruction mixes.
module tb_exec_sequencer;

    localparam int CNT_W     = 32;
    localparam int TIMEOUT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             imem_req_o, imem_ack_i, ir_load_o, first_cycle_o;
    logic             mem_i, store_i, dmem_req_o, dmem_we_o, dmem_ack_i;
    logic             jmp_i, branch_i, taken_i, halt_i;
    logic             pc_en_o, pc_redirect_o, halted_o, mem_err_o;
    logic [CNT_W-1:0] instret_o;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [31:0] exp_ret     = 0;

    exec_sequencer #(.TIMEOUT_W(TIMEOUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .ir_load_o(ir_load_o),
        .first_cycle_o(first_cycle_o), .mem_i(mem_i), .store_i(store_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
        .jmp_i(jmp_i), .branch_i(branch_i), .taken_i(taken_i), .halt_i(halt_i),
        .pc_en_o(pc_en_o), .pc_redirect_o(pc_redirect_o), .halted_o(halted_o),
        .mem_err_o(mem_err_o), .instret_o(instret_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack_i = 0; mem_i = 0; store_i = 0; dmem_ack_i = 0;
        jmp_i = 0; branch_i = 0; taken_i = 0; halt_i = 0;
    endtask

    task automatic check_all_zero(input string tag);
        logic [9:0] got;
        got = {imem_req_o, ir_load_o, first_cycle_o, dmem_req_o, dmem_we_o,
               pc_en_o, pc_redirect_o, halted_o, mem_err_o, |instret_o};
        vectors++;
        if (got !== 10'b0) begin
            miscompares++;
            $display("FAIL %s: outputs got %b expected 0000000000", tag, got);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #3;
        check_all_zero("reset_hold");
        @(negedge clk);
        rst_n  = 1'b1;
        exp_ret = 0;
        #1;
        check_all_zero("idle_cycle");
    endtask

    task automatic wait_fetch(output bit got);
        for (int i = 0; i < 20; i++) begin
            if (imem_req_o === 1'b1) break;
            step();
            #2;
        end
        got = (imem_req_o === 1'b1);
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL fetch_timeout: imem_req_o got %b expected 1", imem_req_o);
        end
    endtask

    // Expected behaviour per instruction: fetch wait fw, ack, one LO cycle, one HI
    // cycle, then dw+1 MEM cycles for memory ops; latency counted from first FETCH cycle.
    task automatic run_instr(input bit is_mem, input bit st, input bit jmp, input bit br,
                             input bit tk, input int fw, input int dw, input bit halt_lo);
        int t0;
        bit got;
        bit exp_red;
        mem_i = is_mem; store_i = st; jmp_i = jmp; branch_i = br; taken_i = tk;
        imem_ack_i = 0; dmem_ack_i = 0;
        exp_red = jmp | (br & tk);
        wait_fetch(got);
        if (!got) return;
        t0 = cyc;
        for (int i = 0; i < fw; i++) begin
            vectors++;
            if (ir_load_o !== 1'b0 || imem_req_o !== 1'b1) begin
                miscompares++;
                $display("FAIL fetch_stall: req/load got %b%b expected 10", imem_req_o, ir_load_o);
            end
            step();
            #2;
        end
        imem_ack_i = 1;
        #1;
        vectors++;
        if (ir_load_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ir_load: got %b expected 1", ir_load_o);
        end
        step();
        imem_ack_i = 0;
        if (halt_lo) halt_i = 1;
        #2;
        vectors++;
        if ({first_cycle_o, pc_en_o, imem_req_o, ir_load_o} !== 4'b1000) begin
            miscompares++;
            $display("FAIL lo_cycle: fc/pc_en/req/load got %b%b%b%b expected 1000",
                     first_cycle_o, pc_en_o, imem_req_o, ir_load_o);
        end
        step();
        #2;
        if (!is_mem) begin
            vectors++;
            if (pc_en_o !== 1'b1 || pc_redirect_o !== exp_red || first_cycle_o !== 1'b0
                || (cyc - t0 + 1) != 3 + fw) begin
                miscompares++;
                $display("FAIL alu_retire: pc_en %b redir %b fc %b lat %0d expected 1 %b 0 %0d",
                         pc_en_o, pc_redirect_o, first_cycle_o, cyc - t0 + 1, exp_red, 3 + fw);
            end
        end else begin
            vectors++;
            if (pc_en_o !== 1'b0 || dmem_req_o !== 1'b0) begin
                miscompares++;
                $display("FAIL hi_mem: pc_en %b dmem_req %b expected 0 0", pc_en_o, dmem_req_o);
            end
            for (int i = 0; i < dw; i++) begin
                step();
                #2;
                vectors++;
                if (dmem_req_o !== 1'b1 || dmem_we_o !== st || pc_en_o !== 1'b0
                    || mem_err_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL mem_wait: req %b we %b pc_en %b err %b expected 1 %b 0 0",
                             dmem_req_o, dmem_we_o, pc_en_o, mem_err_o, st);
                end
            end
            step();
            dmem_ack_i = 1;
            #2;
            vectors++;
            if (dmem_req_o !== 1'b1 || dmem_we_o !== st || pc_en_o !== 1'b1
                || pc_redirect_o !== 1'b0 || (cyc - t0 + 1) != 4 + fw + dw) begin
                miscompares++;
                $display("FAIL mem_retire: req %b we %b pc_en %b redir %b lat %0d expected 1 %b 1 0 %0d",
                         dmem_req_o, dmem_we_o, pc_en_o, pc_redirect_o, cyc - t0 + 1, st, 4 + fw + dw);
            end
        end
        exp_ret = exp_ret + 1;
        step();
        dmem_ack_i = 0;
        #2;
        vectors++;
        if (instret_o !== exp_ret || pc_en_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL post_retire: instret %0d pc_en %b dreq %b expected %0d 0 0",
                     instret_o, pc_en_o, dmem_req_o, exp_ret);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_alu_stream();
        bit got;
        do_reset();
        imem_ack_i = 1;
        wait_fetch(got);
        for (int k = 0; k < 12; k++) begin
            vectors++;
            if (first_cycle_o !== (k % 3 == 1) || pc_en_o !== (k % 3 == 2) || pc_redirect_o !== 1'b0) begin
                miscompares++;
                $display("FAIL stream_k%0d: fc %b pc_en %b redir %b expected %b %b 0",
                         k, first_cycle_o, pc_en_o, pc_redirect_o, k % 3 == 1, k % 3 == 2);
            end
            step();
            #2;
        end
        imem_ack_i = 0;
        exp_ret = 4;
        vectors++;
        if (instret_o !== exp_ret) begin
            miscompares++;
            $display("FAIL stream_instret: got %0d expected 4", instret_o);
        end
    endtask

    task automatic test_branch();
        run_instr(0, 0, 0, 1, 1, 0, 0, 0);
        run_instr(0, 0, 0, 1, 0, 0, 0, 0);
        run_instr(0, 0, 1, 0, 0, 1, 0, 0);
    endtask

    task automatic test_store_delay();
        run_instr(1, 1, 0, 0, 0, 0, 3, 0);
        run_instr(1, 0, 1, 1, 1, 2, 0, 0);
    endtask

    task automatic test_halt();
        run_instr(0, 0, 0, 0, 0, 0, 0, 1);
        vectors++;
        if (imem_req_o !== 1'b0 || halted_o !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_fetch: req %b halted %b expected 0 0", imem_req_o, halted_o);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) halt_i = 0;
            #2;
            vectors++;
            if (imem_req_o !== 1'b0 || halted_o !== 1'b1) begin
                miscompares++;
                $display("FAIL halt_park%0d: req %b halted %b expected 0 1", i, imem_req_o, halted_o);
            end
        end
        step();
        #2;
        vectors++;
        if (imem_req_o !== 1'b1 || halted_o !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_release: req %b halted %b expected 1 0", imem_req_o, halted_o);
        end
        run_instr(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_mem();
        bit got;
        do_reset();
        mem_i = 1; store_i = 1;
        wait_fetch(got);
        imem_ack_i = 1;
        step();
        imem_ack_i = 0;
        step();
        step();
        #2;
        vectors++;
        if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_mem: req %b we %b expected 1 1", dmem_req_o, dmem_we_o);
        end
        dmem_ack_i = 1;
        rst_n = 0;
        #1;
        check_all_zero("async_reset_in_mem");
        do_reset();
    endtask

`ifdef EXEC_SEQ_WDOG_EN
    task automatic test_mem_wait();
        bit got;
        mem_i = 1; store_i = 0; dmem_ack_i = 0;
        wait_fetch(got);
        imem_ack_i = 1;
        step();
        imem_ack_i = 0;
        step();
        for (int i = 1; i <= 16; i++) begin
            step();
            #2;
            vectors++;
            if (pc_en_o !== (i == 16) || dmem_req_o !== 1'b1 || mem_err_o !== 1'b0) begin
                miscompares++;
                $display("FAIL wdog_cycle%0d: pc_en %b req %b err %b expected %b 1 0",
                         i, pc_en_o, dmem_req_o, mem_err_o, i == 16);
            end
        end
        exp_ret = exp_ret + 1;
        step();
        #2;
        vectors++;
        if (mem_err_o !== 1'b1 || imem_req_o !== 1'b1 || dmem_req_o !== 1'b0 || instret_o !== exp_ret) begin
            miscompares++;
            $display("FAIL wdog_expire: err %b req %b dreq %b instret %0d expected 1 1 0 %0d",
                     mem_err_o, imem_req_o, dmem_req_o, instret_o, exp_ret);
        end
    endtask
`else
    task automatic test_mem_wait();
        run_instr(1, 0, 0, 0, 0, 0, 40, 0);
    endtask
`endif

    task automatic test_back_to_back();
        for (int n = 0; n < 30; n++) begin
            run_instr($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                      $urandom_range(0, 4), 0);
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_alu_stream();
        test_branch();
        test_store_delay();
        test_halt();
        test_mem_wait();
        test_back_to_back();
        test_reset_mid_mem();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
